// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: default widths, DMA state encoding and the address map.
package soc_bus_pkg;

   localparam int SOC_ADDR_W = 8;
   localparam int SOC_DATA_W = 8;
   localparam int SOC_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } dma_state_t;

   // Region bounds; the *_AW widths are the offset bits each region spans.
   localparam logic [SOC_ADDR_W-1:0] RAM_BASE   = 8'h00;
   localparam logic [SOC_ADDR_W-1:0] RAM_LAST   = 8'h7F;
   localparam int                    RAM_AW     = 7;
   localparam logic [SOC_ADDR_W-1:0] UART_BASE  = 8'h80;
   localparam logic [SOC_ADDR_W-1:0] UART_LAST  = 8'h8F;
   localparam int                    UART_AW    = 4;
   localparam logic [SOC_ADDR_W-1:0] TIMER_BASE = 8'h90;
   localparam logic [SOC_ADDR_W-1:0] TIMER_LAST = 8'h9F;
   localparam int                    TIMER_AW   = 4;

endpackage

// File: rtl/soc_bus_dma.sv
// Single-channel byte-copy DMA initiator: alternating read/write beats on the SoC bus master port.
//
// state | meaning
// IDLE  | waiting for start; bus idle
// RD    | read beat on src, data captured on accept
// WR    | write beat of buffered byte to dst, counters advance on accept
// DONE  | one-cycle completion pulse
module soc_bus_dma
   import soc_bus_pkg::*;
#(
   parameter int ADDR_W = SOC_ADDR_W,
   parameter int DATA_W = SOC_DATA_W,
   parameter int LEN_W  = SOC_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              src_inc,
   input  logic              dst_inc,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  remaining,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              m_we,
   output logic              m_valid,
   input  logic              m_ready
);

   dma_state_t        state_q, state_d;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [LEN_W-1:0]  rem_q;
   logic [DATA_W-1:0] buf_q;
   logic              src_inc_q, dst_inc_q;
   logic              abort_pend_q, aborted_q;

   logic load, load_zero, rd_acc, wr_acc, end_xfer, pend_now;

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      load_zero = 1'b0;
      rd_acc    = 1'b0;
      wr_acc    = 1'b0;
      end_xfer  = 1'b0;
      // An abort arriving in the same cycle as the write accept ends the transfer too.
      pend_now  = abort_pend_q | abort;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  load    = 1'b1;
                  state_d = ST_RD;
               end else begin
                  load_zero = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_RD: begin
            if (m_ready) begin
               rd_acc  = 1'b1;
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            if (m_ready) begin
               wr_acc = 1'b1;
               if (rem_q == LEN_W'(1) || pend_now) begin
                  end_xfer = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         rem_q        <= '0;
         buf_q        <= '0;
         src_inc_q    <= 1'b0;
         dst_inc_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            rem_q     <= len;
            src_inc_q <= src_inc;
            dst_inc_q <= dst_inc;
         end
         if (load || load_zero) begin
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
         end
         if ((state_q == ST_RD || state_q == ST_WR) && abort) begin
            abort_pend_q <= 1'b1;
         end
         if (rd_acc) begin
            buf_q <= m_rdata;
         end
         if (wr_acc) begin
            rem_q <= (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
            src_q <= src_q + ADDR_W'(src_inc_q);
            dst_q <= dst_q + ADDR_W'(dst_inc_q);
         end
         if (end_xfer) begin
            abort_pend_q <= 1'b0;
            if (pend_now) begin
               aborted_q <= 1'b1;
            end
         end
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign aborted   = aborted_q;
   assign remaining = rem_q;
   assign m_valid   = (state_q == ST_RD) || (state_q == ST_WR);
   assign m_we      = (state_q == ST_WR);
   assign m_addr    = (state_q == ST_RD) ? src_q :
                      (state_q == ST_WR) ? dst_q : '0;
   assign m_wdata   = buf_q;

endmodule
